wshb_arbiter: RTL and testbench
===============================

Name: wshb_arbiter

Overview:
- Two-master / one-slave Wishbone classic arbiter sharing the SDRAM controller slave between the pattern-writer master (m0, the test-pattern generator) and the VGA frame-reader master (m1).
- Registered round-robin grant with a per-grant beat quota, so a streaming master cannot starve the other.
- Sits between the master interfaces and the SDRAM slave; purely a traffic steerer, no buffering of data.

Parameters:
- ADR_W, 32, Wishbone address width (byte address)
- DATA_W, 16, Wishbone data width
- MAX_BURST, 64, acked beats a master may take per grant while the other master waits (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_cyc  in  2  cycle request, bit i = master i
- m_stb  in  2  strobe per master
- m_we  in  2  write enable per master
- m_adr  in  2*ADR_W  addresses, master i at [i*ADR_W +: ADR_W]
- m_sel  in  2*(DATA_W/8)  byte selects per master
- m_dat_ms  in  2*DATA_W  write data per master
- m_dat_sm  out  DATA_W  read data, broadcast to both masters
- m_ack  out  2  ack routed to granted master only
- s_cyc  out  1  to slave
- s_stb  out  1  to slave
- s_we  out  1  to slave
- s_adr  out  ADR_W  to slave
- s_sel  out  DATA_W/8  to slave
- s_dat_ms  out  DATA_W  to slave
- s_dat_sm  in  DATA_W  read data from slave
- s_ack  in  1  ack from slave
- grant  out  2  one-hot current owner (00 = none), debug/status

Behaviour:
- FSM states IDLE, G0, G1; grant = {state==G1, state==G0}; all transitions on clk edge.
- last register: index of master granted most recently; reset 1 (so m0 wins first contention).
- IDLE: one requester -> grant it next cycle; both -> grant !last; none -> stay. Grant latency: 1 cycle from m_cyc rise to s_cyc rise.
- Gi: if m_cyc[i]==0 -> go G(other) if m_cyc[other] else IDLE (direct handover, no dead cycle).
- Quota: beat counter cnt, width $clog2(MAX_BURST+1), cleared on every grant change, +1 per s_ack while granted, saturates at MAX_BURST. If s_ack && cnt>=MAX_BURST-1 && m_cyc[other] -> go G(other) at that edge (the acked beat completes normally). Without a competing request the owner keeps the grant indefinitely.
- Preempted master keeps cyc/stb high and simply sees no ack until re-granted; it has priority at next contention via last.
- Slave mux (combinational from state): in Gi, s_cyc=m_cyc[i], s_stb=m_stb[i], s_we/adr/sel/dat_ms = master i fields; in IDLE all s_* = 0.
- m_ack[i] = s_ack && state==Gi; m_ack = 00 in IDLE. m_dat_sm = s_dat_sm always.
- s_ack arriving in IDLE is ignored (not routed, not counted).
- Reset (async, any time incl. mid-transfer): state IDLE, last=1, cnt=0 -> s_cyc=s_stb=0, grant=00, m_ack=00 immediately, no clock required.

Test Plan:
- Reset then m_cyc=01, m_stb=01, m_adr[0]=0x100, slave acks 1 cycle later -> s_cyc rises 1 cycle after m_cyc, s_adr=0x100, grant=01, m_ack=01 only.
- m_cyc=11 from IDLE after reset -> grant=01 first; m0 drops cyc -> grant=10 on next edge, no IDLE cycle.
- MAX_BURST=4, m1 holds cyc/stb, slave acks every cycle, m0 requests at beat 2 -> exactly 4 acks to m1, then grant=01, m1 sees m_ack[1]=0 until m0 releases.
- m1 alone streams 200 acked beats, no m0 request -> grant stays 10 throughout, counter saturates, no spurious handover.
- s_ack pulsed while grant=00 -> m_ack stays 00, cnt unchanged.
- rst_n low mid-burst during G1 with s_ack high -> s_cyc, s_stb, grant, m_ack all 0 asynchronously; after release, m_cyc=11 -> grant=01.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter with registered round-robin
// grant and a per-grant beat quota so neither master can starve the other.
module wshb_arbiter #(
    parameter int unsigned ADR_W     = 32,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              m_cyc,
    input  logic [1:0]              m_stb,
    input  logic [1:0]              m_we,
    input  logic [2*ADR_W-1:0]      m_adr,
    input  logic [2*(DATA_W/8)-1:0] m_sel,
    input  logic [2*DATA_W-1:0]     m_dat_ms,
    output logic [DATA_W-1:0]       m_dat_sm,
    output logic [1:0]              m_ack,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADR_W-1:0]        s_adr,
    output logic [DATA_W/8-1:0]     s_sel,
    output logic [DATA_W-1:0]       s_dat_ms,
    input  logic [DATA_W-1:0]       s_dat_sm,
    input  logic                    s_ack,
    output logic [1:0]              grant
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               quota_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next grant: IDLE picks !last on contention; owner hands over on release or quota.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        quota_hit = s_ack && (cnt_q >= CNT_W'(MAX_BURST - 1));

        case (state_q)
            IDLE: begin
                if (m_cyc == 2'b11)  state_d = last_q ? G0 : G1;
                else if (m_cyc[0])   state_d = G0;
                else if (m_cyc[1])   state_d = G1;
            end
            G0: begin
                if (!m_cyc[0])                   state_d = m_cyc[1] ? G1 : IDLE;
                else if (quota_hit && m_cyc[1])  state_d = G1;
            end
            G1: begin
                if (!m_cyc[1])                   state_d = m_cyc[0] ? G0 : IDLE;
                else if (quota_hit && m_cyc[0])  state_d = G0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == G0 && state_q != G0) last_d = 1'b0;
        if (state_d == G1 && state_q != G1) last_d = 1'b1;

        // Beats counted only while granted; saturate so long streams never wrap.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE && s_ack && cnt_q < CNT_W'(MAX_BURST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slave-side steering straight from the grant state.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_ms = '0;
        case (state_q)
            G0: begin
                s_cyc    = m_cyc[0];
                s_stb    = m_stb[0];
                s_we     = m_we[0];
                s_adr    = m_adr[0 +: ADR_W];
                s_sel    = m_sel[0 +: SEL_W];
                s_dat_ms = m_dat_ms[0 +: DATA_W];
            end
            G1: begin
                s_cyc    = m_cyc[1];
                s_stb    = m_stb[1];
                s_we     = m_we[1];
                s_adr    = m_adr[ADR_W +: ADR_W];
                s_sel    = m_sel[SEL_W +: SEL_W];
                s_dat_ms = m_dat_ms[DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    assign grant    = {state_q == G1, state_q == G0};
    assign m_ack    = {s_ack && state_q == G1, s_ack && state_q == G0};
    assign m_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: grant latency, handover, quota preemption,
// saturation without contention, IDLE ack filtering and async reset.
module tb_wshb_arbiter;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = DATA_W / 8;
    localparam int unsigned MB     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            m_cyc, m_stb, m_we;
    logic [2*ADR_W-1:0]    m_adr;
    logic [2*SEL_W-1:0]    m_sel;
    logic [2*DATA_W-1:0]   m_dat_ms;
    logic [DATA_W-1:0]     m_dat_sm;
    logic [1:0]            m_ack;
    logic                  s_cyc, s_stb, s_we;
    logic [ADR_W-1:0]      s_adr;
    logic [SEL_W-1:0]      s_sel;
    logic [DATA_W-1:0]     s_dat_ms;
    logic [DATA_W-1:0]     s_dat_sm;
    logic                  s_ack;
    logic [1:0]            grant;

    int n_checks = 0;
    int n_fail   = 0;

    wshb_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_sel(m_sel), .m_dat_ms(m_dat_ms), .m_dat_sm(m_dat_sm), .m_ack(m_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks1;
        int bad_grant;

        rst_n    = 1'b0;
        m_cyc    = 2'b00;
        m_stb    = 2'b00;
        m_we     = 2'b00;
        m_adr    = '0;
        m_sel    = '0;
        m_dat_ms = '0;
        s_dat_sm = '0;
        s_ack    = 1'b0;
        #12;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_s_cyc", 64'(s_cyc), 64'h0);
        check("rst_m_ack", 64'(m_ack), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single master m0: one-cycle grant latency and field steering
        m_cyc    = 2'b01;
        m_stb    = 2'b01;
        m_we     = 2'b01;
        m_adr    = {32'h0000_0200, 32'h0000_0100};
        m_sel    = 4'b0111;
        m_dat_ms = {16'hCAFE, 16'hBEEF};
        #1;
        check("t1_s_cyc_before", 64'(s_cyc), 64'h0);
        tick();
        check("t1_grant", 64'(grant), 64'h1);
        check("t1_s_cyc", 64'(s_cyc), 64'h1);
        check("t1_s_stb", 64'(s_stb), 64'h1);
        check("t1_s_adr", 64'(s_adr), 64'h100);
        check("t1_s_we", 64'(s_we), 64'h1);
        check("t1_s_sel", 64'(s_sel), 64'h3);
        check("t1_s_dat", 64'(s_dat_ms), 64'hBEEF);
        s_ack    = 1'b1;
        s_dat_sm = 16'h1234;
        #1;
        check("t1_m_ack", 64'(m_ack), 64'h1);
        check("t1_m_dat_sm", 64'(m_dat_sm), 64'h1234);
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        check("t1_idle", 64'(grant), 64'h0);

        // Contention after reset: m0 first, direct handover to m1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = 2'b00;
        tick();
        check("t2_grant_m0", 64'(grant), 64'h1);
        check("t2_s_adr0", 64'(s_adr), 64'h100);
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t2_grant_m1", 64'(grant), 64'h2);
        check("t2_s_adr1", 64'(s_adr), 64'h200);
        check("t2_s_sel1", 64'(s_sel), 64'h1);

        // Quota: m1 streams, m0 requests after beat 2, m1 gets exactly 4 beats
        acks1 = 0;
        s_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                m_cyc = 2'b11;
                m_stb = 2'b11;
            end
            #1;
            if (m_ack[1]) acks1++;
            tick();
        end
        s_ack = 1'b0;
        check("t3_m1_beats", 64'(acks1), 64'd4);
        check("t3_grant_m0", 64'(grant), 64'h1);
        for (int i = 0; i < 3; i++) tick();
        s_ack = 1'b1;
        #1;
        check("t3_m1_starved", 64'(m_ack), 64'h1);
        s_ack = 1'b0;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t3_regrant_m1", 64'(grant), 64'h2);

        // m1 alone: 200 beats, grant never moves, counter saturates
        acks1     = 0;
        bad_grant = 0;
        s_ack     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (m_ack == 2'b10) acks1++;
            if (grant != 2'b10) bad_grant++;
            tick();
        end
        s_ack = 1'b0;
        check("t4_acks", 64'(acks1), 64'd200);
        check("t4_grant_moves", 64'(bad_grant), 64'd0);
        check("t4_cnt_sat", 64'(dut.cnt_q), 64'(MB));

        // Ack in IDLE is dropped and not counted
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();
        check("t5_idle", 64'(grant), 64'h0);
        s_ack = 1'b1;
        #1;
        check("t5_m_ack", 64'(m_ack), 64'h0);
        tick();
        s_ack = 1'b0;
        check("t5_cnt", 64'(dut.cnt_q), 64'h0);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        check("t5_rr_m0", 64'(grant), 64'h1);

        // Async reset mid-burst in G1 with s_ack high
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t6_grant_m1", 64'(grant), 64'h2);
        s_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_s_cyc", 64'(s_cyc), 64'h0);
        check("t6_s_stb", 64'(s_stb), 64'h0);
        check("t6_grant", 64'(grant), 64'h0);
        check("t6_m_ack", 64'(m_ack), 64'h0);
        s_ack = 1'b0;
        #1;
        rst_n = 1'b1;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        check("t6_after_rst", 64'(grant), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
